seq_divider_4_bit: RTL
======================

SEQ_DIVIDER_4_BIT -- requirements
Module: seq_divider_4_bit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand width; only 4 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  4  unsigned dividend, sampled with start.
REQ-006 divisor  input  4  unsigned divisor, sampled with start.
REQ-007 busy  output  1  high from the accepting edge until the DONE state is left.
REQ-008 done  output  1  one-cycle pulse; results are valid from that cycle onward.
REQ-009 quotient  output  4  unsigned quotient.
REQ-010 remainder  output  4  unsigned remainder.
REQ-011 div_by_zero  output  1  set when the accepted divisor was 0.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1, the edge SHALL:
- load Q=dividend, R=0, D=divisor;
- clear the iteration counter;
- load div_by_zero=(divisor==0);
- set busy=1;
- move the FSM to RUN.
REQ-014 In IDLE with start=0, all registers SHALL hold.
REQ-015 Each RUN edge SHALL perform one restoring step:
- form the 5-bit shifted remainder S={R,Q[3]} and shift Q left;
- if S>=D, set R=S-D and Q[0]=1;
- otherwise set R=S[3:0] and Q[0]=0.
REQ-016 The S>=D test and S-D SHALL be computed as {R[2:0],Q[3]} + ~D + 1 on the 4-bit adder, taking success as (R[3] OR carry-out).
REQ-017 RUN SHALL last exactly 4 edges; the 4th edge SHALL move the FSM to DONE.
REQ-018 done SHALL be high for exactly the one cycle the FSM spends in DONE; the next edge SHALL return to IDLE with busy=0.
REQ-019 Latency SHALL be fixed: done is first visible after the 5th rising edge, counting the start-sampling edge as the 1st.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing.
REQ-021 quotient, remainder and div_by_zero SHALL hold from done until the next accepted start.
REQ-022 Divisor 0 SHALL take the normal 4-cycle path and yield quotient=4'hF, remainder=dividend, div_by_zero=1.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every divisor != 0.
REQ-024 Dividend < divisor SHALL yield quotient=0, remainder=dividend.

Reset
REQ-025 rst_n=0 SHALL immediately, at any time including mid-RUN, force:
- state=IDLE;
- busy=0, done=0;
- quotient=0, remainder=0, div_by_zero=0;
- counter=0.
REQ-026 An in-flight division SHALL be abandoned at reset and SHALL NOT produce done.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-028 The shared package div_pkg SHALL hold:
- the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
- the constants WIDTH=4 and ITERATIONS=4.
REQ-029 The subtract SHALL use one instance of the existing rca_4_bit (ports a, b, cin, cout, sum) with b=~D and cin=1.
REQ-030 All other logic (FSM, 2-bit counter, Q/R/D registers) SHALL reside in this module.

Verification
REQ-031 14/3: start=1 for one cycle -> done after edge 5; quotient=4, remainder=2, div_by_zero=0.
REQ-032 11/14 -> quotient=0, remainder=11; 15/1 -> quotient=15, remainder=0.
REQ-033 9/0 -> quotient=15, remainder=9, div_by_zero=1, same latency.
REQ-034 Start 14/3, then hold start=1 with 15/5 through RUN -> only the 14/3 result appears, done pulses once, busy never drops early.
REQ-035 Start 14/3, pull rst_n low after edge 3 -> outputs immediately 0, no done; a new 15/5 afterwards -> quotient=3, remainder=0.
REQ-036 Exhaustive sweep of all 256 dividend/divisor pairs -> every result matches REQ-022/REQ-023, each with latency 5.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encodings and sizing constants for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  localparam int WIDTH      = 4;
  localparam int ITERATIONS = 4;
endpackage

// File: rtl/rca_4_bit.sv
// rca_4_bit: 4-bit ripple-carry adder.
module rca_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] sum
);
  logic [4:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

// File: rtl/seq_divider_4_bit.sv
// seq_divider_4_bit: 4-bit restoring divider, one quotient bit per RUN cycle,
// fixed latency of five edges from the accepting edge to done.
module seq_divider_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div_pkg::*;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [3:0]       shifted, diff;
  logic             cout, fits;
  assign shifted = {r_q[2:0], q_q[3]};
  rca_4_bit u_rca (
    .a   (shifted),
    .b   (~d_q),
    .cin (1'b1),
    .cout(cout),
    .sum (diff)
  );
  // R[3] is the 5th bit of the shifted remainder, so the subtract always fits when set
  assign fits = r_q[3] | cout;
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (start) begin
        q_d     = dividend;
        r_d     = '0;
        d_d     = divisor;
        cnt_d   = '0;
        dbz_d   = (divisor == '0);
        state_d = RUN;
      end
      RUN: begin
        q_d     = {q_q[2:0], fits};
        r_d     = fits ? diff : shifted;
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'(ITERATIONS - 1)) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
endmodule
